// File: rtl/st2bus_pkg.sv
// st2bus shared types: FSM states, header layout, slot math.
// Used by st2bus and st2bus_hdr.
package st2bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_WAIT
  } state_t;

  localparam int HDR_FIRST  = 15;
  localparam int HDR_LAST   = 14;
  localparam int HDR_LERR   = 13;
  localparam int HDR_SEQ_HI = 12;
  localparam int HDR_SEQ_LO = 9;
  localparam int HDR_CNT_HI = 8;
  localparam int HDR_CNT_LO = 0;

  // Samples that fit in one bus payload.
  function automatic int nst_of(input int payload, input int st);
    return payload / st;
  endfunction

  // Header carries the bus index mod 16.
  function automatic logic [3:0] seq_of(input logic [31:0] idx);
    return idx[3:0];
  endfunction

endpackage

// File: rtl/st2bus_hdr.sv
// st2bus header builder: packs flags, bus index
// and sample count into the 16-bit header.
module st2bus_hdr
  import st2bus_pkg::*;
#(
  parameter int BUS_HEAD = 16,
  parameter int CW       = 9
) (
  input  logic                first,
  input  logic                last,
  input  logic                lerr,
  input  logic [3:0]          seq,
  input  logic [CW-1:0]       cnt,
  output logic [BUS_HEAD-1:0] hdr
);

  // Assemble header fields.
  always_comb begin
    hdr = '0;
    hdr[HDR_FIRST] = first;
    hdr[HDR_LAST]  = last;
    hdr[HDR_LERR]  = lerr;
    hdr[HDR_SEQ_HI:HDR_SEQ_LO] = seq;
    hdr[HDR_CNT_HI:HDR_CNT_LO] = cnt;
  end

endmodule

// File: rtl/st2bus.sv
// st2bus: packs Avalon-ST samples into 512-bit bus words.
// Optional ST2BUS_LEN_CHECK_EN adds st_len/len_err frame check.
module st2bus
  import st2bus_pkg::*;
#(
`ifdef ST2BUS_LEN_CHECK_EN
  parameter int w_NumOfST_in_AFUFrm  = 16,
`endif
  parameter int BUS                  = 512,
  parameter int BUS_HEAD             = 16,
  parameter int BUS_PAYLOAD          = 496,
  parameter int ST                   = 24,
  parameter int w_NumofST_in_Bus     = 9,
  parameter int w_NumOfBUS_in_AFUFrm = 11
) (
  input  logic                           clk,
  input  logic                           rst_n,
`ifdef ST2BUS_LEN_CHECK_EN
  input  logic [w_NumOfST_in_AFUFrm-1:0] st_len,
  output logic                           len_err,
`endif
  input  logic [ST-1:0]                  st_data,
  input  logic                           st_valid,
  input  logic                           st_sop,
  input  logic                           st_eop,
  output logic                           st_ready,
  output logic [BUS-1:0]                 bus_data,
  output logic                           bus_en,
  input  logic                           bus_ready
);

  localparam int NST = nst_of(BUS_PAYLOAD, ST);
  localparam int CW  = w_NumofST_in_Bus;
  localparam int BW  = w_NumOfBUS_in_AFUFrm;
  localparam logic [CW-1:0] LAST_SLOT = CW'(NST - 1);

  state_t                 state;
  logic [BUS_PAYLOAD-1:0] payload;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          idx_q;
  logic                   first_q;
  logic                   last_q;
  logic                   lerr_q;
  logic [3:0]             seq;
  logic [BUS_HEAD-1:0]    hdr;
  logic                   acc;
  logic                   start;
  logic                   emit;

  // st_ready is low in S_WAIT, so sop beats here
  // only arrive in S_IDLE or S_PACK.
  assign acc   = st_valid & st_ready;
  assign start = acc & st_sop;
  assign emit  = (state == S_WAIT) & bus_ready;
  assign seq   = seq_of(32'(idx_q));

  st2bus_hdr #(
    .BUS_HEAD(BUS_HEAD),
    .CW      (CW)
  ) u_hdr (
    .first(first_q),
    .last (last_q),
    .lerr (lerr_q),
    .seq  (seq),
    .cnt  (cnt_q),
    .hdr  (hdr)
  );

  // Packing FSM with registered handshake and bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      st_ready <= 1'b0;
      bus_en   <= 1'b0;
      bus_data <= '0;
      payload  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      bus_en <= 1'b0;
      if (start) begin
        payload  <= BUS_PAYLOAD'(st_data);
        cnt_q    <= CW'(1);
        idx_q    <= '0;
        first_q  <= 1'b1;
        last_q   <= st_eop;
        state    <= st_eop ? S_WAIT : S_PACK;
        st_ready <= ~st_eop;
      end else begin
        unique case (state)
          S_IDLE: st_ready <= 1'b1;
          S_PACK: begin
            st_ready <= 1'b1;
            if (acc) begin
              payload[32'(cnt_q)*ST +: ST] <= st_data;
              cnt_q <= cnt_q + 1'b1;
              if (st_eop || cnt_q == LAST_SLOT) begin
                state    <= S_WAIT;
                last_q   <= st_eop;
                st_ready <= 1'b0;
              end
            end
          end
          S_WAIT: begin
            st_ready <= bus_ready;
            if (bus_ready) begin
              bus_en   <= 1'b1;
              bus_data <= {payload, hdr};
              payload  <= '0;
              cnt_q    <= '0;
              first_q  <= 1'b0;
              idx_q    <= idx_q + 1'b1;
              state    <= last_q ? S_IDLE : S_PACK;
            end
          end
          default: begin
            state    <= S_IDLE;
            st_ready <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ST2BUS_LEN_CHECK_EN
  localparam int LW = w_NumOfST_in_AFUFrm;

  logic [LW-1:0] beats_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] beats_nx;
  logic [LW-1:0] len_ref;

  assign beats_nx = st_sop ? LW'(1) : beats_q + 1'b1;
  assign len_ref  = st_sop ? st_len : len_q;

  // Count framed beats; flag a length mismatch on eop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q <= '0;
      len_q   <= '0;
      lerr_q  <= 1'b0;
      len_err <= 1'b0;
    end else begin
      len_err <= emit & last_q & lerr_q;
      if (start || (acc && state == S_PACK)) begin
        beats_q <= beats_nx;
        lerr_q  <= st_eop & (beats_nx != len_ref);
        if (st_sop) len_q <= st_len;
      end
    end
  end
`else
  assign lerr_q = 1'b0;
`endif

endmodule

// File: tb/tb_st2bus.sv
// st2bus bench: directed frames with literal expectations
// plus random frames checked against a queue-based model.
module tb_st2bus;

  localparam int ST  = 24;
  localparam int NST = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] st_data = '0;
  logic        st_valid = 1'b0;
  logic        st_sop = 1'b0;
  logic        st_eop = 1'b0;
  logic        st_ready;
  logic [511:0] bus_data;
  logic        bus_en;
  logic        bus_ready = 1'b1;
  logic [15:0] st_len = '0;
  logic        len_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  bit rnd_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  st2bus dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef ST2BUS_LEN_CHECK_EN
    .st_len   (st_len),
    .len_err  (len_err),
`endif
    .st_data  (st_data),
    .st_valid (st_valid),
    .st_sop   (st_sop),
    .st_eop   (st_eop),
    .st_ready (st_ready),
    .bus_data (bus_data),
    .bus_en   (bus_en),
    .bus_ready(bus_ready)
  );

`ifndef ST2BUS_LEN_CHECK_EN
  assign len_err = 1'b0;
`endif

  // model state
  bit          m_in;
  bit          m_first;
  int          m_bidx;
  int          m_beats;
  int          m_len;
  logic [23:0] m_cur[$];
  logic [511:0] exp_q[$];
  bit          explerr_q[$];
  logic [511:0] got_q[$];
  int          gotcyc_q[$];
  bit          gotlerr_q[$];

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_word(input bit last, input bit lerr);
    logic [511:0] w;
    w = '0;
    w[15:0] = {m_first, last, lerr, 4'(m_bidx), 9'(m_cur.size())};
    foreach (m_cur[k]) w[16+ST*k +: ST] = m_cur[k];
    return w;
  endfunction

  task automatic model_reset();
    m_in = 0;
    m_cur.delete();
    exp_q.delete();
    explerr_q.delete();
  endtask

  task automatic model_beat(input logic [23:0] d, input bit s,
                            input bit e, input int len);
    bit le;
    le = 0;
    if (s) begin
      m_in = 1; m_first = 1; m_bidx = 0;
      m_beats = 0; m_len = len;
      m_cur.delete();
    end
    if (!m_in) return;
    m_cur.push_back(d);
    m_beats++;
    if (e || m_cur.size() == NST) begin
`ifdef ST2BUS_LEN_CHECK_EN
      le = e && (m_beats != m_len);
`endif
      exp_q.push_back(mk_word(e, le));
      explerr_q.push_back(le);
      m_first = 0;
      m_bidx++;
      m_cur.delete();
      if (e) m_in = 0;
    end
  endtask

  // Compare process: every bus_en against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      if (bus_en) begin
        got_q.push_back(bus_data);
        gotcyc_q.push_back(cyc);
        gotlerr_q.push_back(len_err);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_bus_en got=%h want=none", bus_data);
        end else begin
          chk("model_word", bus_data, exp_q.pop_front());
`ifdef ST2BUS_LEN_CHECK_EN
          chk("model_len_err", 512'(len_err), 512'(explerr_q.pop_front()));
`endif
        end
      end
`ifdef ST2BUS_LEN_CHECK_EN
      if (len_err && !bus_en) begin
        checks++; failures++;
        $display("FAIL len_err_alone got=1 want=0");
      end
`endif
      if (st_valid && st_ready)
        model_beat(st_data, st_sop, st_eop, int'(st_len));
    end
  end

  // Drivers start and end at posedge+1.
  task automatic beat(input logic [23:0] d, input bit s, input bit e,
                      input int gap);
    st_valid = 0;
    repeat (gap) begin @(posedge clk); #1; end
    st_data = d; st_sop = s; st_eop = e; st_valid = 1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (st_ready) break;
      if (n > 300) begin
        checks++; failures++;
        $display("FAIL beat_timeout got=stall want=ready");
        st_valid = 0;
        return;
      end
    end
    last_acc = cyc;
    @(posedge clk); #1;
    st_valid = 0; st_sop = 0; st_eop = 0;
  endtask

  task automatic frame(input int n, input int base);
    st_len = 16'(n);
    for (int i = 0; i < n; i++)
      beat(24'(base + i), i == 0, i == n - 1, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic clear_got();
    got_q.delete(); gotcyc_q.delete(); gotlerr_q.delete();
  endtask

  initial begin
    logic [511:0] e;
    bit bad;

    #1 rst_n = 0;
    #1;
    chk("reset_bus_data", bus_data, '0);
    chk("reset_flags", 512'({bus_en, st_ready}), '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // 20-beat frame
    clear_got();
    frame(20, 1);
    drain();
    chk("t1_count", 512'(got_q.size()), 512'(1));
    e = '0;
    e[15:0] = 16'hC014;
    for (int k = 0; k < 20; k++) e[16+ST*k +: ST] = 24'(k + 1);
    chk("t1_word", got_q[0], e);
    chk("t1_latency", 512'(gotcyc_q[0] - last_acc), 512'(2));

    // 45-beat frame
    clear_got();
    frame(45, 1);
    drain();
    chk("t2_count", 512'(got_q.size()), 512'(3));
    chk("t2_hdr0", 512'(got_q[0][15:0]), 512'(16'h8014));
    chk("t2_hdr1", 512'(got_q[1][15:0]), 512'(16'h0214));
    chk("t2_hdr2", 512'(got_q[2][15:0]), 512'(16'h4405));
    chk("t2_slot0_b2", 512'(got_q[2][16 +: 24]), 512'(41));
    chk("t2_pad_b2", got_q[2] >> (16 + ST * 5), '0);

    // bus_ready stall in S_WAIT
    clear_got();
    bus_ready = 0;
    frame(20, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (st_ready || bus_en) bad = 1;
    end
    chk("t3_hold", 512'(bad), '0);
    chk("t3_none_yet", 512'(got_q.size()), '0);
    bus_ready = 1;
    @(posedge clk); #1;
    drain();
    chk("t3_count", 512'(got_q.size()), 512'(1));
    e[15:0] = 16'hC014;
    chk("t3_word", got_q[0], e);

    // single sop+eop beat
    clear_got();
    st_len = 16'd1;
    beat(24'hABCDEF, 1, 1, 0);
    drain();
    e = '0;
    e[15:0] = 16'hC001;
    e[39:16] = 24'hABCDEF;
    chk("t4_word", got_q[0], e);

    // stray beats in idle, then 5-beat frame
    clear_got();
    for (int i = 0; i < 3; i++) beat(24'h777 + 24'(i), 0, 0, 0);
    frame(5, 10);
    drain();
    chk("t5_count", 512'(got_q.size()), 512'(1));
    chk("t5_hdr", 512'(got_q[0][15:0]), 512'(16'hC005));
    chk("t5_slot0", 512'(got_q[0][16 +: 24]), 512'(10));

    // sop mid-frame restarts
    clear_got();
    st_len = 16'd4;
    for (int i = 0; i < 3; i++) beat(24'(i + 1), i == 0, 0, 0);
    for (int i = 0; i < 4; i++) beat(24'h100 + 24'(i), i == 0, i == 3, 0);
    drain();
    chk("t5b_count", 512'(got_q.size()), 512'(1));
    chk("t5b_hdr", 512'(got_q[0][15:0]), 512'(16'hC004));
    chk("t5b_slot0", 512'(got_q[0][16 +: 24]), 512'(24'h100));

    // reset mid-frame
    clear_got();
    st_len = 16'd7;
    for (int i = 0; i < 7; i++) beat(24'(i + 50), i == 0, 0, 0);
    rst_n = 0;
    #1;
    chk("t6_bus_data", bus_data, '0);
    chk("t6_flags", 512'({bus_en, st_ready}), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    frame(2, 200);
    drain();
    chk("t6_count", 512'(got_q.size()), 512'(1));
    chk("t6_hdr", 512'(got_q[0][15:0]), 512'(16'hC002));

`ifdef ST2BUS_LEN_CHECK_EN
    clear_got();
    st_len = 16'd10;
    for (int i = 0; i < 9; i++) beat(24'(i + 1), i == 0, i == 8, 0);
    drain();
    chk("t7_hdr", 512'(got_q[0][15:0]), 512'(16'hE009));
    chk("t7_len_err", 512'(gotlerr_q[0]), 512'(1));
    clear_got();
    frame(3, 5);
    drain();
    chk("t7b_hdr", 512'(got_q[0][15:0]), 512'(16'hC003));
    chk("t7b_len_err", 512'(gotlerr_q[0]), '0);
`endif

    // random frames against the model
    rnd_on = 1;
    fork
      begin
        for (int f = 0; f < 150; f++) begin
          int len;
          int cut;
          len = $urandom_range(1, 50);
          cut = ($urandom_range(0, 9) == 0) ? $urandom_range(1, len) : len;
          if ($urandom_range(0, 4) == 0)
            beat(24'($urandom), 0, 0, $urandom_range(0, 2));
          st_len = ($urandom_range(0, 1) == 1) ? 16'(len)
                                                : 16'($urandom_range(1, 60));
          for (int i = 0; i < cut; i++)
            beat(24'($urandom), i == 0, i == len - 1,
                 ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          bus_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus_ready = 1;
    drain();
    chk("rand_drained", 512'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/st2bus.md
Name: st2bus

Overview:
- Return-path packer: collects Avalon-ST samples (decoded output of TurboDecoder) and packs them into 512-bit bus words for memory write-back.
- Each bus word carries a 16-bit header in the low bits and a 496-bit payload.
- Header bit 14 marks the last bus of an AFU frame, so the frame format is symmetric with the memory-to-decoder input path.
- Datapath: TurboDecoder -> st2bus -> memory.

Parameters:
- BUS, 512: bus width in bits.
- BUS_HEAD, 16: header width; occupies bus_data[15:0].
- BUS_PAYLOAD, 496: payload width; occupies bus_data[511:16].
- ST, 24: stream sample width.
- w_NumofST_in_Bus, 9: width of the per-bus sample count field.
- w_NumOfBUS_in_AFUFrm, 11: width of the internal bus-in-frame counter.
- w_NumOfST_in_AFUFrm, 16: width of the frame sample counter.
- Derived localparam NST = BUS_PAYLOAD/ST (20 at default); NST must be >= 2.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- st_data, input, ST: sample.
- st_valid, input, 1: sample valid.
- st_sop, input, 1: first sample of frame.
- st_eop, input, 1: last sample of frame.
- st_ready, output, 1: block accepts a sample this cycle.
- bus_data, output, BUS: packed word; valid only when bus_en=1.
- bus_en, output, 1: single-cycle write strobe.
- bus_ready, input, 1: downstream can take a word.

Behaviour:
- Reset: rst_n low forces, immediately and asynchronously, bus_en=0, bus_data=0, st_ready=0, state S_IDLE, slot count 0, bus counter 0, packed payload cleared. A frame in progress is discarded.
- Accept: a beat is accepted when st_valid & st_ready. st_ready=1 in S_IDLE and S_PACK, 0 in S_WAIT and during reset.
- Slot placement: slot k sits at bus_data[16+ST*(k+1)-1 : 16+ST*k]. Unfilled slots and the pad bits above slot NST-1 are 0.
- Header fields:
  - [15] first bus of frame.
  - [14] last bus of frame.
  - [13] length error (0 unless the macro is enabled).
  - [12:9] bus index within frame, mod 16.
  - [8:0] number of valid samples in this bus (1..NST).
- S_IDLE: accepted beats without st_sop are dropped. A sop beat goes to slot 0, count=1, first flag set, bus index=0. If the same beat has eop, go to S_WAIT with last=1; otherwise go to S_PACK.
- S_PACK: an accepted beat goes to slot[count], count+1. If count reaches NST or the beat has eop, go to S_WAIT and latch last=eop.
- S_PACK, sop mid-frame: the partial word and frame are discarded, and the beat restarts the frame at slot 0.
- S_WAIT: hold the word while bus_ready=0; no output, no samples accepted. On a cycle with bus_ready=1:
  - next cycle bus_en=1 with bus_data={payload, header};
  - payload and count are cleared, first flag is cleared, bus index increments (wraps);
  - next state is S_IDLE if last, else S_PACK.
- bus_en is high for exactly one cycle per word.
- Latency: bus_en asserts 2 cycles after the closing beat is accepted, given bus_ready=1.
- Throughput: one word per NST+1 cycles under continuous input.
- Frames longer than 2^w_NumOfBUS_in_AFUFrm buses: the bus counter wraps silently.

Optional Feature:
- ST2BUS_LEN_CHECK_EN defined:
  - adds input st_len [w_NumOfST_in_AFUFrm-1:0], sampled on the sop beat;
  - adds output len_err (1 bit, reset 0);
  - beats are counted per frame; on the eop beat the count is compared with st_len;
  - on mismatch, header[13]=1 on the last bus, and len_err pulses 1 cycle, coincident with that bus_en.
- Undefined: neither port exists, header[13]=0, no counter is built.

Decomposition:
- Package st2bus_pkg holds:
  - state enum {S_IDLE, S_PACK, S_WAIT};
  - header bit-position constants (FIRST=15, LAST=14, LERR=13, SEQ 12:9, CNT 8:0);
  - function computing NST from BUS_PAYLOAD and ST.
- Sub-module st2bus_hdr: combinational header builder from first, last, lerr, seq and count. Everything else stays in st2bus.

Test Plan:
- 20-beat frame, data 1..20, bus_ready=1 -> one bus_en; header 0xC014; slot k = k+1; bus_en 2 cycles after beat 20.
- 45-beat frame -> three buses with headers 0x8014, 0x0214, 0x4405; the third bus has slots 5..19 = 0.
- bus_ready low for 10 cycles while in S_WAIT -> st_ready=0, bus_en=0 throughout; word emitted once, unchanged, after bus_ready rises; no beat lost.
- Single beat with sop=eop=1, data 0xABCDEF -> header 0xC001, slot0=0xABCDEF, rest 0.
- Three non-sop beats in S_IDLE, then a 5-beat frame -> one bus with header 0xC005 holding only the framed beats. A second sop after beat 3 of a frame -> the first 3 beats never appear.
- rst_n pulsed low mid-frame after 7 beats -> outputs 0 immediately; a following 2-beat frame gives header 0xC002. With ST2BUS_LEN_CHECK_EN, st_len=10 on a 9-beat frame -> header 0xE009, len_err pulse aligned with bus_en.
